// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and the
// request legality rule.
package lsu_pkg;

    localparam int MEM_IDX_W = 12;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_DONE
    } lsu_state_e;

    // Unsigned widths exist only for loads; H/W must be naturally aligned.
    function automatic logic req_illegal(input logic we, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage and the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// sub-word store merge into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_sh      = {off, 3'b000};
        half_sh      = {off[1], 4'b0000};
        byte_shifted = rdata >> byte_sh;
        byte_v       = byte_shifted[7:0];
        half_v       = off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_BU:   load_data = {24'b0, byte_v};
            F3_HU:   load_data = {16'b0, half_v};
            default: load_data = rdata;
        endcase

        // Clear the target lane, then OR in the new data shifted into place.
        case (funct3)
            F3_B:    store_data = (rdata & ~(32'h0000_00FF << byte_sh))
                                | ({24'b0, wdata[7:0]} << byte_sh);
            F3_H:    store_data = (rdata & ~(32'h0000_FFFF << half_sh))
                                | ({16'b0, wdata[15:0]} << half_sh);
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, byte/half loads with extension,
// read-modify-write for sub-word stores, single response per request.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus,
    output logic               mem_write_en,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data
);

    lsu_state_e  state;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] load_data;
    logic [31:0] store_data;
    logic        illegal;

    lsu_align u_align (
        .funct3     (funct3_q),
        .off        (addr_q[1:0]),
        .rdata      (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        illegal        = req_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
        bus.req_ready  = (state == ST_IDLE);
        bus.resp_valid = resp_valid_q;
        bus.resp_rdata = resp_rdata_q;
        bus.resp_err   = resp_err_q;
        mem_addr       = {2'b00, addr_q[31:2]};
        // Gated by rst so a store caught mid-flight by reset never lands.
        mem_write_en   = (state == ST_WR) && !rst;
        mem_write_data = wbuf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wbuf_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        funct3_q     <= bus.req_funct3;
                        addr_q       <= bus.req_addr;
                        wdata_q      <= bus.req_wdata;
                        wbuf_q       <= bus.req_wdata;
                        resp_rdata_q <= '0;
                        resp_err_q   <= illegal;
                        if (illegal) begin
                            state        <= ST_DONE;
                            resp_valid_q <= 1'b1;
                        end else if (!bus.req_we) begin
                            state <= ST_RD;
                        end else if (bus.req_funct3 == F3_W) begin
                            state <= ST_WR;
                        end else begin
                            state <= ST_RMW_RD;
                        end
                    end
                end
                ST_RD: begin
                    resp_rdata_q <= load_data;
                    resp_valid_q <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_RMW_RD: begin
                    wbuf_q <= store_data;
                    state  <= ST_WR;
                end
                ST_WR: begin
                    resp_valid_q <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory with negedge read, byte-addressed
// reference model, directed cases followed by randomized traffic.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DEPTH = 1 << MEM_IDX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Data memory: index truncated to MEM_IDX_W bits, read registered on negedge.
    logic [31:0] mem [DEPTH];
    always @(negedge clk) mem_read_data <= mem[mem_addr[MEM_IDX_W-1:0]];
    always @(posedge clk) if (mem_write_en) mem[mem_addr[MEM_IDX_W-1:0]] <= mem_write_data;

    int wr_cnt = 0;
    int resp_cnt = 0;
    always @(posedge clk) if (mem_write_en) wr_cnt++;
    always @(posedge clk) if (bus.resp_valid) resp_cnt++;

    int total = 0;
    int bad = 0;

    // Reference model: plain byte-addressed memory.
    logic [7:0] ref_b [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (addr % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        int base;
        logic [31:0] v;
        n = size_of(f3);
        base = int'(addr[MEM_IDX_W+1:0]);
        v = '0;
        for (int i = 0; i < n; i++) v = v | ({24'b0, ref_b[base + i]} << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int base;
        logic [31:0] d;
        base = int'(addr[MEM_IDX_W+1:0]);
        d = wdata;
        for (int i = 0; i < size_of(f3); i++) begin
            ref_b[base + i] = d[7:0];
            d = d >> 8;
        end
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got);
        logic        e;
        logic [31:0] exp_rd;
        logic [31:0] r;
        int          exp_lat;
        int          exp_wr;
        int          lat;
        int          w0;
        int          waitc;

        e       = ref_err(we, f3, addr);
        exp_rd  = (e || we) ? 32'h0 : ref_load(f3, addr);
        exp_lat = e ? 0 : ((we && f3 != F3_W) ? 2 : 1);
        exp_wr  = (e || !we) ? 0 : 1;
        if (!e && we) ref_store(f3, addr, wdata);

        @(negedge clk);
        waitc = 0;
        while (!bus.req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        check("ready_before_req", {31'b0, bus.req_ready}, 32'd1);

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        // Scramble the request bus; the unit must ignore it while busy.
        r = $urandom;
        bus.req_valid  = 1'b0;
        bus.req_we     = r[0];
        bus.req_funct3 = r[3:1];
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        check("ready_busy", {31'b0, bus.req_ready}, 32'd0);

        lat = 0;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("resp_seen", {31'b0, bus.resp_valid}, 32'd1);
        check("latency", lat, exp_lat);
        check("rdata", bus.resp_rdata, exp_rd);
        check("err", {31'b0, bus.resp_err}, {31'b0, e});
        got = bus.resp_rdata;

        @(posedge clk);
        #1;
        check("resp_pulse", {31'b0, bus.resp_valid}, 32'd0);
        check("ready_after", {31'b0, bus.req_ready}, 32'd1);
        check("write_count", wr_cnt - w0, exp_wr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] w;
        logic [31:0] r;
        int          acc;
        int          r0;
        int          w0;

        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
        end

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst_mem_we", {31'b0, mem_write_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);

        // Word store/load and sub-word merge
        do_op(1'b1, F3_W, 32'h100, 32'hDEADBEEF, got);
        do_op(1'b0, F3_W, 32'h100, 32'h0, got);
        check("lw_deadbeef", got, 32'hDEADBEEF);
        do_op(1'b1, F3_B, 32'h101, 32'h0000005A, got);
        do_op(1'b0, F3_W, 32'h100, 32'h0, got);
        check("sb_merge", got, 32'hDEAD5AEF);

        // Extraction and extension
        do_op(1'b0, F3_B, 32'h103, 32'h0, got);
        check("lb_sign", got, 32'hFFFFFFDE);
        do_op(1'b0, F3_BU, 32'h103, 32'h0, got);
        check("lbu_zero", got, 32'h000000DE);
        do_op(1'b0, F3_H, 32'h102, 32'h0, got);
        check("lh_sign", got, 32'hFFFFDEAD);
        do_op(1'b0, F3_HU, 32'h102, 32'h0, got);
        check("lhu_zero", got, 32'h0000DEAD);
        do_op(1'b1, F3_H, 32'h102, 32'h00001234, got);
        do_op(1'b0, F3_W, 32'h100, 32'h0, got);
        check("sh_merge", got, 32'h12345AEF);

        // Illegal requests leave memory untouched
        do_op(1'b0, F3_W, 32'h102, 32'h0, got);
        do_op(1'b1, F3_H, 32'h101, 32'hFFFFFFFF, got);
        do_op(1'b0, 3'b011, 32'h100, 32'h0, got);
        do_op(1'b1, F3_BU, 32'h100, 32'hFFFFFFFF, got);
        do_op(1'b0, F3_W, 32'h100, 32'h0, got);
        check("mem_unchanged", got, 32'h12345AEF);

        // Reset during the WR cycle of a word store
        do_op(1'b1, F3_W, 32'h200, 32'hCAFEF00D, got);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h200;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("wr_state_we", {31'b0, mem_write_en}, 32'd1);
        rst = 1'b1;
        r0 = resp_cnt;
        w0 = wr_cnt;
        #1;
        check("rst_gates_we", {31'b0, mem_write_en}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready_idle", {31'b0, bus.req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_write", wr_cnt - w0, 32'd0);
        check("rst_no_resp", resp_cnt - r0, 32'd0);
        do_op(1'b0, F3_W, 32'h200, 32'h0, got);
        check("rst_old_value", got, 32'hCAFEF00D);

        // Aliasing above 16KB
        do_op(1'b1, F3_W, 32'h4000, 32'h00000001, got);
        do_op(1'b0, F3_W, 32'h0, 32'h0, got);
        check("alias_lw", got, 32'h00000001);

        // req_valid held high: one response per accept, one accept per 3 cycles
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h0;
        acc = 0;
        r0 = resp_cnt;
        repeat (30) begin
            if (bus.req_ready) acc++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stream_accepts", acc, 32'd10);
        check("stream_resps", resp_cnt - r0, acc);
        check("stream_rdata", bus.resp_rdata, 32'h00000001);

        // Randomized traffic over a small window plus alias bits
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            r = $urandom;
            a = ({30'b0, r[1:0]} << 14) | ({26'b0, r[7:2]} << 2) | {30'b0, r[9:8]};
            do_op(r[10], r[13:11], a, $urandom, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
